// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align -- load/store alignment unit between the MEM stage and the
// word-organised data memory bus.
//
// Store path: moves right-justified sub-word store data into its byte lane(s)
// and generates byte enables. Load path: selects the addressed lane from the
// returned bus word and zero- or sign-extends it to 32 bits. One bus
// transaction is sequenced per request with a wait-state timeout.
//
// Parameters:
//   TIMEOUT     max cycles in BUS without bus_ack before a bus error (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   req_valid   request present (held by requester until accepted)
//   req_ready   unit can accept a request
//   req_we      1 = store, 0 = load
//   req_op      000 word, 001 half s, 010 half u, 011 byte s, 100 byte u
//   req_addr    byte address
//   req_wdata   store data, right-justified
//   bus_req     bus transaction active
//   bus_we      bus write strobe
//   bus_addr    word address {req_addr[31:2], 2'b00}
//   bus_be      byte enables
//   bus_wdata   lane-aligned store data
//   bus_ack     transaction complete
//   bus_rdata   read word, valid with bus_ack
//   resp_valid  response present
//   resp_ready  consumer accepts response
//   resp_rdata  extended load data (0 for stores and errors)
//   resp_err    00 ok, 01 misaligned, 10 bus timeout, 11 illegal op
// -----------------------------------------------------------------------------
module lsu_align #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value on the last permitted wait cycle; one more ack-less cycle
  // makes it reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HS   = 3'b001;
  localparam logic [2:0] OP_HU   = 3'b010;
  localparam logic [2:0] OP_BS   = 3'b011;
  localparam logic [2:0] OP_BU   = 3'b100;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Data-path helpers
  // ---------------------------------------------------------------------------

  function automatic logic f_op_illegal(input logic [2:0] op);
    logic r;
    case (op)
      OP_WORD, OP_HS, OP_HU, OP_BS, OP_BU: r = 1'b0;
      default:                             r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic r;
    case (op)
      OP_WORD:      r = (off != 2'b00);
      OP_HS, OP_HU: r = off[0];
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] f_byte_enable(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] r;
    case (op)
      OP_WORD:      r = 4'b1111;
      OP_HS, OP_HU: r = off[1] ? 4'b1100 : 4'b0011;
      OP_BS, OP_BU: r = 4'b0001 << off;
      default:      r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicating the sub-word across the word puts it in every lane, so the
  // byte enables alone select where it lands.
  function automatic logic [31:0] f_store_lanes(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] r;
    case (op)
      OP_WORD:      r = wdata;
      OP_HS, OP_HU: r = {wdata[15:0], wdata[15:0]};
      OP_BS, OP_BU: r = {4{wdata[7:0]}};
      default:      r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] f_load_extend(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] rdata);
    logic [15:0] lane_h;
    logic [7:0]  lane_b;
    logic [31:0] r;
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    case (off)
      2'b00:   lane_b = rdata[7:0];
      2'b01:   lane_b = rdata[15:8];
      2'b10:   lane_b = rdata[23:16];
      2'b11:   lane_b = rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    case (op)
      OP_WORD: r = rdata;
      OP_HS:   r = {{16{lane_h[15]}}, lane_h};
      OP_HU:   r = {16'h0000, lane_h};
      OP_BS:   r = {{24{lane_b[7]}}, lane_b};
      OP_BU:   r = {24'h00_0000, lane_b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             lat_we_r, lat_we_s;
  logic [2:0]       lat_op_r, lat_op_s;
  logic [1:0]       lat_off_r, lat_off_s;

  logic             req_ready_r, req_ready_s;
  logic             bus_req_r, bus_req_s;
  logic             bus_we_r, bus_we_s;
  logic [31:0]      bus_addr_r, bus_addr_s;
  logic [3:0]       bus_be_r, bus_be_s;
  logic [31:0]      bus_wdata_r, bus_wdata_s;
  logic             resp_valid_r, resp_valid_s;
  logic [31:0]      resp_rdata_r, resp_rdata_s;
  logic [1:0]       resp_err_r, resp_err_s;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    lat_we_s     = lat_we_r;
    lat_op_s     = lat_op_r;
    lat_off_s    = lat_off_r;
    req_ready_s  = req_ready_r;
    bus_req_s    = bus_req_r;
    bus_we_s     = bus_we_r;
    bus_addr_s   = bus_addr_r;
    bus_be_s     = bus_be_r;
    bus_wdata_s  = bus_wdata_r;
    resp_valid_s = resp_valid_r;
    resp_rdata_s = resp_rdata_r;
    resp_err_s   = resp_err_r;

    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid) begin
          lat_we_s    = req_we;
          lat_op_s    = req_op;
          lat_off_s   = req_addr[1:0];
          req_ready_s = 1'b0;
          cnt_s       = '0;
          if (f_op_illegal(req_op)) begin
            state_s      = ST_RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = 32'h0000_0000;
            resp_err_s   = ERR_OP;
          end else if (f_misaligned(req_op, req_addr[1:0])) begin
            state_s      = ST_RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = 32'h0000_0000;
            resp_err_s   = ERR_ALIGN;
          end else begin
            state_s     = ST_BUS;
            bus_req_s   = 1'b1;
            bus_we_s    = req_we;
            bus_addr_s  = {req_addr[31:2], 2'b00};
            bus_be_s    = f_byte_enable(req_op, req_addr[1:0]);
            bus_wdata_s = f_store_lanes(req_op, req_wdata);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUS: begin
        // An ack in the final permitted cycle is checked first, so it wins
        // over the timeout.
        if (bus_ack) begin
          state_s      = ST_RESP;
          cnt_s        = '0;
          bus_req_s    = 1'b0;
          bus_we_s     = 1'b0;
          resp_valid_s = 1'b1;
          resp_err_s   = ERR_OK;
          if (lat_we_r) begin
            resp_rdata_s = 32'h0000_0000;
          end else begin
            resp_rdata_s = f_load_extend(lat_op_r, lat_off_r, bus_rdata);
          end
        end else if (cnt_r == CNT_LAST) begin
          state_s      = ST_RESP;
          cnt_s        = '0;
          bus_req_s    = 1'b0;
          bus_we_s     = 1'b0;
          resp_valid_s = 1'b1;
          resp_rdata_s = 32'h0000_0000;
          resp_err_s   = ERR_TMO;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_s      = ST_IDLE;
          resp_valid_s = 1'b0;
          req_ready_s  = 1'b1;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        // Unreachable encoding: return to a quiet, ready state.
        state_s      = ST_IDLE;
        cnt_s        = '0;
        req_ready_s  = 1'b1;
        bus_req_s    = 1'b0;
        bus_we_s     = 1'b0;
        resp_valid_s = 1'b0;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      lat_we_r     <= 1'b0;
      lat_op_r     <= 3'b000;
      lat_off_r    <= 2'b00;
      req_ready_r  <= 1'b1;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_addr_r   <= 32'h0000_0000;
      bus_be_r     <= 4'b0000;
      bus_wdata_r  <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 2'b00;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      lat_we_r     <= lat_we_s;
      lat_op_r     <= lat_op_s;
      lat_off_r    <= lat_off_s;
      req_ready_r  <= req_ready_s;
      bus_req_r    <= bus_req_s;
      bus_we_r     <= bus_we_s;
      bus_addr_r   <= bus_addr_s;
      bus_be_r     <= bus_be_s;
      bus_wdata_r  <= bus_wdata_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign bus_req    = bus_req_r;
  assign bus_we     = bus_we_r;
  assign bus_addr   = bus_addr_r;
  assign bus_be     = bus_be_r;
  assign bus_wdata  = bus_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_lsu_align.sv
// -----------------------------------------------------------------------------
// tb_lsu_align -- self-checking bench for lsu_align (TIMEOUT = 4).
// Directed vectors from a table, hand-written reset sequences, and random
// requests checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_lsu_align;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_align #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_wait;   // wait cycles before ack; >= TMO means never
    int          hold;       // cycles resp_ready stays low
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  err;
    int          cyc;        // expected bus_req high cycles
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on lane size and offset.
  function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int ack_wait,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] rd, output logic [1:0] err, output int cyc);
    int size;
    int off;
    longint mask;
    longint lane;
    off = int'(addr % 32'd4);
    case (op)
      3'd0:       size = 4;
      3'd1, 3'd2: size = 2;
      3'd3, 3'd4: size = 1;
      default:    size = 0;
    endcase
    be = 4'b0000; wd = 32'h0; rd = 32'h0; cyc = 0;
    if (size == 0) begin
      err = 2'b11;
    end else if ((off % size) != 0) begin
      err = 2'b01;
    end else begin
      be   = 4'(((1 << size) - 1) << off);
      mask = (64'sd1 <<< (8 * size)) - 64'sd1;
      if (size == 4)      wd = wdata;
      else if (size == 2) wd = (wdata & 32'h0000_FFFF) * 32'h0001_0001;
      else                wd = (wdata & 32'h0000_00FF) * 32'h0101_0101;
      if (ack_wait + 1 > TMO) begin
        err = 2'b10;
        cyc = TMO;
      end else begin
        err = 2'b00;
        cyc = ack_wait + 1;
        if (!we) begin
          lane = (longint'(rdata) >> (8 * off)) & mask;
          if ((op == 3'd1 || op == 3'd3) && lane >= (mask + 1) / 2)
            lane = lane - (mask + 1);
          rd = 32'(lane);
        end
      end
    end
  endfunction

  // One full request/bus/response exchange; entered and left at posedge+1.
  task automatic run_txn(input string tag, input vec_t v);
    int  k;
    int  bcyc;
    bit  got;
    chk({tag, " req_ready idle"}, req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    chk({tag, " req_ready busy"}, req_ready, 0);
    k = 0; bcyc = 0; got = 1'b0;
    while (!got && k <= TMO + 4) begin
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (bus_req) begin
          bcyc++;
          chk($sformatf("%s bus_addr c%0d", tag, bcyc), bus_addr, v.addr & 32'hFFFF_FFFC);
          chk($sformatf("%s bus_be c%0d", tag, bcyc), bus_be, v.be);
          chk($sformatf("%s bus_we c%0d", tag, bcyc), bus_we, v.we);
          if (v.we) chk($sformatf("%s bus_wdata c%0d", tag, bcyc), bus_wdata, v.wd);
          bus_ack   = (bcyc == v.ack_wait + 1);
          bus_rdata = bus_ack ? v.rdata : $urandom;
        end else begin
          bus_ack = 1'b0;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        k++;
      end
    end
    chk({tag, " resp seen"}, got, 1);
    chk({tag, " bus cycles"}, bcyc, v.cyc);
    chk({tag, " resp latency"}, k, v.cyc);
    chk({tag, " bus_req low at resp"}, bus_req, 0);
    // Hold off the consumer; stray acks must not disturb the response.
    for (int h = 0; h < v.hold; h++) begin
      resp_ready = 1'b0;
      bus_ack = 1'($urandom);
      chk($sformatf("%s hold%0d valid", tag, h), resp_valid, 1);
      chk($sformatf("%s hold%0d rdata", tag, h), resp_rdata, v.rd);
      chk($sformatf("%s hold%0d err", tag, h), resp_err, v.err);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    chk({tag, " resp_valid"}, resp_valid, 1);
    chk({tag, " resp_rdata"}, resp_rdata, v.rd);
    chk({tag, " resp_err"}, resp_err, v.err);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, resp_valid, 0);
    chk({tag, " req_ready back"}, req_ready, 1);
    chk({tag, " bus_req idle"}, bus_req, 0);
  endtask

  initial begin
    vec_t rv;
    // we op addr wdata rdata ack_wait hold be wd rd err cyc
    vecs[0]  = '{1'b0, 3'b011, 32'h0000_0003, 32'h0, 32'h8012_3456, 2, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b00, 3};
    vecs[1]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, 0, 4'b1100, 32'h0, 32'h0000_BEEF, 2'b00, 1};
    vecs[2]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, 0, 4'b1100, 32'h0, 32'hFFFF_BEEF, 2'b00, 1};
    vecs[3]  = '{1'b1, 3'b011, 32'h0000_0011, 32'h0000_00A5, 32'hDEAD_BEEF, 1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 2'b00, 2};
    vecs[4]  = '{1'b0, 3'b000, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b01, 0};
    vecs[5]  = '{1'b0, 3'b110, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b11, 0};
    vecs[6]  = '{1'b0, 3'b000, 32'h0000_0020, 32'h0, 32'h1234_5678, 10, 0, 4'b1111, 32'h0, 32'h0, 2'b10, 4};
    vecs[7]  = '{1'b0, 3'b000, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, 3, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 2'b00, 4};
    vecs[8]  = '{1'b0, 3'b011, 32'h0000_0003, 32'h0, 32'h8012_3456, 0, 3, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b00, 1};
    vecs[9]  = '{1'b1, 3'b001, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0, 2'b00, 1};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_0001, 32'h1234_ABCD, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b01, 0};
    vecs[11] = '{1'b0, 3'b100, 32'h0000_0005, 32'h0, 32'h0000_F000, 0, 0, 4'b0010, 32'h0, 32'h0000_00F0, 2'b00, 1};
    vecs[12] = '{1'b1, 3'b000, 32'h0000_0100, 32'h1234_5678, 32'h0, 2, 1, 4'b1111, 32'h1234_5678, 32'h0, 2'b00, 3};
    vecs[13] = '{1'b1, 3'b100, 32'h0000_0007, 32'hFFFF_FF3C, 32'h0, 0, 0, 4'b1000, 32'h3C3C_3C3C, 32'h0, 2'b00, 1};
    vecs[14] = '{1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h0000_7FFF, 1, 0, 4'b0011, 32'h0, 32'h0000_7FFF, 2'b00, 2};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", req_ready, 1);
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_be", bus_be, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst resp_err", resp_err, 0);
    reset = 1'b0;
    // Stray ack while idle must be ignored.
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("stray ack bus_req", bus_req, 0);
    chk("stray ack resp_valid", resp_valid, 0);

    for (int i = 0; i < 15; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted mid-BUS aborts at once and produces no response.
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0000_0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst bus_req before", bus_req, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("midrst bus_req async", bus_req, 0);
    chk("midrst req_ready async", req_ready, 1);
    chk("midrst resp_valid async", resp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ack = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst no resp c%0d", c), resp_valid, 0);
      chk($sformatf("midrst no bus c%0d", c), bus_req, 0);
    end
    bus_ack = 1'b0; resp_ready = 1'b0;
    run_txn("postrst", vecs[1]);

    // Random requests against the reference model.
    for (int r = 0; r < 60; r++) begin
      rv.we       = 1'($urandom);
      rv.op       = 3'($urandom_range(0, 7));
      rv.addr     = $urandom;
      rv.wdata    = $urandom;
      rv.rdata    = $urandom;
      rv.ack_wait = $urandom_range(0, 5);
      rv.hold     = $urandom_range(0, 2);
      model(rv.we, rv.op, rv.addr, rv.wdata, rv.rdata, rv.ack_wait,
            rv.be, rv.wd, rv.rd, rv.err, rv.cyc);
      run_txn($sformatf("rnd%0d", r), rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
